// File: rtl/dmem_port_arbiter.sv
// Shares the MEM-stage data memory between the pipeline and a debug port; cpu has priority, dbg is forced in after MAX_WAIT cycles.
// Memory pins are combinational from the owner; dbg_ack 2 cycles after grant; cpu stalled in DACC. Optional stats: DMEM_ARB_STATS_EN.
module dmem_port_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]   stat_stall,
  output logic [15:0]   stat_dbg,
`endif
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_DACC, S_DACK} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t        state_q, state_d;
  logic [3:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] dbg_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wait_cnt_q  <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      // Captured for writes too: the requester sees the post-write word.
      if (state_q == S_DACC) dbg_rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dbg_req && (!cpu_req || wait_cnt_q == WAIT_LAST)) begin
          state_d    = S_DACC;
          wait_cnt_d = '0;
        end else if (dbg_req && cpu_req) begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
          wait_cnt_d = '0;
        end
      end
      S_DACC: begin
        state_d    = S_DACK;
        wait_cnt_d = '0;
      end
      S_DACK:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = cpu_we & cpu_req & ~reset;
    cpu_stall = 1'b0;
    dbg_ack   = 1'b0;
    case (state_q)
      S_DACC: begin
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
        mem_we    = dbg_we & dbg_req & ~reset;
        cpu_stall = cpu_req & ~reset;
      end
      S_DACK:  dbg_ack = ~reset;
      default: ;
    endcase
  end

  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = dbg_rdata_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_stall_q, stat_dbg_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_stall_q <= '0;
      stat_dbg_q   <= '0;
    end else begin
      if (cpu_stall && stat_stall_q != 16'hFFFF) stat_stall_q <= stat_stall_q + 16'd1;
      if (dbg_ack && stat_dbg_q != 16'hFFFF)     stat_dbg_q   <= stat_dbg_q + 16'd1;
    end
  end

  assign stat_stall = stat_stall_q;
  assign stat_dbg   = stat_dbg_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed reset cases, then directed and random traffic against a timestamp-based reference model.
module tb_dmem_port_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;

  typedef struct {
    logic          stall;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdat;
  } cyc_exp_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] dat;
  } rd_exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dbg_req, dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_stall, stat_dbg;
`endif

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
`ifdef DMEM_ARB_STATS_EN
    .stat_stall(stat_stall), .stat_dbg(stat_dbg),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory: combinational read, write on the falling edge.
  logic [DW-1:0] mem [32];
  logic          mem_init = 1'b1;

  function automatic logic [DW-1:0] init_val(int i);
    return (32'(i) * 32'h0001_0203) ^ 32'hA5A5_0000;
  endfunction

  always @(negedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  cyc_exp_t exp_cyc[$];
  rd_exp_t  exp_ack[$];
  rd_exp_t  exp_rd[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Reference model state: abstract dbg transaction timestamps.
  logic [DW-1:0] ref_mem [32];
  logic d_active = 1'b0, d_granted = 1'b0, prev_stall = 1'b0;
  int   d_r, d_g;
  int   n_stall_model = 0, n_ack_model = 0;

  task automatic step(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                      input logic [DW-1:0] cwd, input logic dnew, input logic dwe,
                      input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
    int c;
    cyc_exp_t ce;
    rd_exp_t  re;
    @(posedge clk); #1;
    c = cyc;
    if (d_active && d_granted && c == d_g + 3) d_active = 1'b0;
    if (!d_active) begin
      dbg_req = dnew;
      if (dnew) begin
        dbg_we = dwe; dbg_addr = daddr; dbg_wdata = dwd;
        d_active = 1'b1; d_granted = 1'b0; d_r = c;
      end
    end
    if (!prev_stall) begin
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
    end
    // dbg has waited c-d_r busy cycles; grant on an idle cpu or at the limit.
    if (d_active && !d_granted && (!cpu_req || c - d_r == MAX_WAIT - 1)) begin
      d_granted = 1'b1; d_g = c;
    end
    ce.stall = 1'b0; ce.we = 1'b0; ce.addr = '0; ce.wdat = '0;
    if (d_active && d_granted && c == d_g + 1) begin
      ce.stall = cpu_req; ce.we = dbg_we; ce.addr = dbg_addr; ce.wdat = dbg_wdata;
      if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
      re.cyc = c + 1; re.dat = ref_mem[dbg_addr];
      exp_ack.push_back(re);
      n_ack_model++;
    end else if (cpu_req) begin
      ce.we = cpu_we; ce.addr = cpu_addr; ce.wdat = cpu_wdata;
      if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
      else begin
        re.cyc = c; re.dat = ref_mem[cpu_addr];
        exp_rd.push_back(re);
      end
    end
    prev_stall = ce.stall;
    if (ce.stall) n_stall_model++;
    exp_cyc.push_back(ce);
  endtask

  // Monitor: compares every checked cycle against the queued expectations.
  initial begin
    cyc_exp_t ce;
    rd_exp_t  re;
    forever begin
      @(posedge clk); #3;
      if (chk_en) begin
        if (exp_cyc.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL cyc_queue cyc=%0d actual=empty expected=entry", cyc);
        end else begin
          ce = exp_cyc.pop_front();
          chk("cpu_stall", DW'(cpu_stall), DW'(ce.stall));
          chk("mem_we", DW'(mem_we), DW'(ce.we));
          if (ce.we) begin
            chk("mem_addr", DW'(mem_addr), DW'(ce.addr));
            chk("mem_wdata", mem_wdata, ce.wdat);
          end
        end
        if (exp_ack.size() > 0 && exp_ack[0].cyc == cyc) begin
          re = exp_ack.pop_front();
          chk("dbg_ack", DW'(dbg_ack), 32'd1);
          chk("dbg_rdata", dbg_rdata, re.dat);
        end else begin
          chk("dbg_ack_idle", DW'(dbg_ack), 32'd0);
        end
        if (exp_rd.size() > 0 && exp_rd[0].cyc == cyc) begin
          re = exp_rd.pop_front();
          chk("cpu_rdata", cpu_rdata, re.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int pct;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_val(i);

    // Reset held with every requester active.
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 5'd3; cpu_wdata = 32'h1111_1111;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd4; dbg_wdata = 32'h2222_2222;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      if (i == 1) mem_init = 1'b0;
      chk("rst_mem_we", DW'(mem_we), 32'd0);
      chk("rst_dbg_ack", DW'(dbg_ack), 32'd0);
      chk("rst_cpu_stall", DW'(cpu_stall), 32'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0; dbg_req = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0;
    #2;
    chk("post_rst_dbg_rdata", dbg_rdata, 32'd0);
    chk("post_rst_stall", DW'(cpu_stall), 32'd0);

    // Reset during DACC of a dbg write to addr 7 aborts it.
    @(posedge clk); #1;
    cpu_req = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd7; dbg_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("abort_mem_we", DW'(mem_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; dbg_req = 1'b0;
    #2;
    chk("abort_no_ack", DW'(dbg_ack), 32'd0);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd7;
    #2;
    chk("abort_addr7", cpu_rdata, ref_mem[7]);
    chk("abort_ack2", DW'(dbg_ack), 32'd0);
    #1;
    cpu_req = 1'b0;
    chk_en = 1'b1;

    // cpu idle; dbg write DEADBEEF to addr 5, then cpu reads it back.
    step(0, 0, 0, 0, 1, 1, 5'd5, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 5'd5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // cpu busy every cycle; dbg forced in after MAX_WAIT, run twice.
    for (int k = 0; k < 2; k++) begin
      step(1, 0, 5'd5, 0, 1, 0, 5'd9, 0);
      for (int i = 0; i < 7; i++) step(1, 0, 5'(i), 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Same-cycle request with a cpu store: cpu wins that cycle.
    step(1, 1, 5'd9, 32'h1234_5678, 1, 0, 5'd9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic at several cpu load levels.
    for (int seg = 0; seg < 4; seg++) begin
      pct = (seg == 0) ? 20 : (seg == 1) ? 60 : (seg == 2) ? 90 : 100;
      for (int i = 0; i < 150; i++) begin
        step($urandom_range(0, 99) < pct, $urandom_range(0, 2) == 0, AW'($urandom),
             $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             AW'($urandom), $urandom);
      end
    end

    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    chk_en = 1'b0;
    chk("leftover_acks", DW'(exp_ack.size()), 32'd0);
    chk("leftover_reads", DW'(exp_rd.size()), 32'd0);
`ifdef DMEM_ARB_STATS_EN
    chk("stat_stall", DW'(stat_stall), DW'(n_stall_model));
    chk("stat_dbg", DW'(stat_dbg), DW'(n_ack_model));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
